// File: rtl/alu_pkg.sv
// Shared ALU control encodings, flag bit positions and arbiter FSM state
// encoding used by alu_core, alu_arbiter and the interface users.
package alu_pkg;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_OR  = 2'b11
  } alu_ctrl_e;

  // rsp_flags / ALUFlags layout is {N, Z, C, V}
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } state_e;

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between two ALU requesters, one consumer and the
// shared alu_arbiter. master = requester/consumer side, slave = arbiter.
interface alu_arbiter_if #(parameter int WIDTH = 5);

  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic [1:0]       req0_ctrl;

  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic [1:0]       req1_ctrl;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_result;
  logic [3:0]       rsp_flags;
  logic             rsp_id;

  modport master (
    output req0_valid, req0_a, req0_b, req0_ctrl,
    output req1_valid, req1_a, req1_b, req1_ctrl,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_result, rsp_flags, rsp_id
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_ctrl,
    input  req1_valid, req1_a, req1_b, req1_ctrl,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_result, rsp_flags, rsp_id
  );

endinterface

// File: rtl/alu_core.sv
// Combinational ALU: add/sub/and/or with {N, Z, C, V} flags. Subtraction is
// a + ~b + 1, so C = 1 means no borrow.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 5
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  alu_ctrl_e        alu_control_i,
  output logic [WIDTH-1:0] result_o,
  output logic [3:0]       alu_flags_o
);

  logic             is_sub;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] res;
  logic             carry;
  logic             ovf;

  always_comb begin
    is_sub = (alu_control_i == ALU_SUB);
    b_eff  = is_sub ? ~b_i : b_i;
    sum    = {1'b0, a_i} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};
    res    = '0;
    carry  = 1'b0;
    ovf    = 1'b0;
    case (alu_control_i)
      ALU_ADD, ALU_SUB: begin
        res   = sum[WIDTH-1:0];
        carry = sum[WIDTH];
        ovf   = (a_i[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a_i[WIDTH-1]);
      end
      ALU_AND: res = a_i & b_i;
      ALU_OR:  res = a_i | b_i;
      default: res = '0;
    endcase
  end

  always_comb begin
    alu_flags_o         = '0;
    alu_flags_o[FLAG_N] = res[WIDTH-1];
    alu_flags_o[FLAG_Z] = (res == '0);
    alu_flags_o[FLAG_C] = carry;
    alu_flags_o[FLAG_V] = ovf;
  end

  assign result_o = res;

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared ALU: grant in IDLE,
// compute in EXEC, hold a registered response in RESP until accepted.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH = 5
) (
  input logic          clk,
  input logic          reset,
  alu_arbiter_if.slave bus
);

  state_e           state_q, state_d;
  logic             prio_q, prio_d;
  logic [WIDTH-1:0] a_q, b_q;
  alu_ctrl_e        ctrl_q;
  logic             id_q;
  logic [WIDTH-1:0] result_q;
  logic [3:0]       flags_q;
  logic             rsp_id_q;

  logic             grant0, grant1;
  logic [WIDTH-1:0] alu_result;
  logic [3:0]       alu_flags;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .a_i           (a_q),
    .b_i           (b_q),
    .alu_control_i (ctrl_q),
    .result_o      (alu_result),
    .alu_flags_o   (alu_flags)
  );

  // Grants are gated by reset so no ready can appear before the first edge
  // with reset low.
  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    grant0  = 1'b0;
    grant1  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!reset) begin
          grant0 = bus.req0_valid && (!bus.req1_valid || !prio_q);
          grant1 = bus.req1_valid && (!bus.req0_valid ||  prio_q);
          if (grant0 || grant1) begin
            state_d = ST_EXEC;
            prio_d  = grant0;
          end
        end
      end
      ST_EXEC: state_d = ST_RESP;
      ST_RESP: if (bus.rsp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      prio_q   <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      ctrl_q   <= ALU_ADD;
      id_q     <= 1'b0;
      result_q <= '0;
      flags_q  <= '0;
      rsp_id_q <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      if (grant0 || grant1) begin
        a_q    <= grant1 ? bus.req1_a : bus.req0_a;
        b_q    <= grant1 ? bus.req1_b : bus.req0_b;
        ctrl_q <= alu_ctrl_e'(grant1 ? bus.req1_ctrl : bus.req0_ctrl);
        id_q   <= grant1;
      end
      if (state_q == ST_EXEC) begin
        result_q <= alu_result;
        flags_q  <= alu_flags;
        rsp_id_q <= id_q;
      end
    end
  end

  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;
  assign bus.rsp_valid  = (state_q == ST_RESP);
  assign bus.rsp_result = result_q;
  assign bus.rsp_flags  = flags_q;
  assign bus.rsp_id     = rsp_id_q;

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 5, operand/result width in bits.
REQ-002 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have ports reqN_valid  input  1  requester N (N=0,1) has an operation pending.
REQ-005 SHALL have ports reqN_ready  output  1  requester N operation accepted this cycle.
REQ-006 SHALL have ports reqN_a, reqN_b  input  WIDTH  operands of requester N.
REQ-007 SHALL have ports reqN_ctrl  input  2  ALUControl of requester N: 00 add, 01 sub, 10 and, 11 or.
REQ-008 SHALL have port rsp_valid  output  1  response available.
REQ-009 SHALL have port rsp_ready  input  1  consumer accepts response.
REQ-010 SHALL have port rsp_result  output  WIDTH  operation result.
REQ-011 SHALL have port rsp_flags  output  4  {N, Z, C, V}.
REQ-012 SHALL have port rsp_id  output  1  index of the requester that issued the operation.

Function
REQ-013 SHALL implement FSM with states IDLE, EXEC, RESP.
REQ-014 IDLE: if any reqN_valid, SHALL grant one requester, assert its reqN_ready combinationally in that cycle, capture a/b/ctrl/id, go to EXEC; else stay.
REQ-015 Arbitration SHALL be round-robin: single request granted directly; both valid -> requester named by priority pointer wins.
REQ-016 Priority pointer SHALL move to the non-winning requester when a grant occurs; reset value selects requester 0.
REQ-017 reqN_ready SHALL be 0 in EXEC and RESP; at most one reqN_ready high per cycle.
REQ-018 EXEC: SHALL compute on captured operands and register result/flags/id; go to RESP unconditionally (one cycle).
REQ-019 RESP: rsp_valid SHALL be 1; rsp_result/flags/id SHALL hold stable until rsp_valid&&rsp_ready, then go to IDLE.
REQ-020 Latency: grant in cycle T -> rsp_valid first high in cycle T+2; peak throughput one operation per 3 cycles.
REQ-021 Add: result = (a+b) mod 2^WIDTH; sub: a + ~b + 1 mod 2^WIDTH; and/or bitwise.
REQ-022 N = result[WIDTH-1]; Z = (result == 0).
REQ-023 C = carry out of bit WIDTH-1 of the add/sub sum (sub: 1 = no borrow); C = 0 for and/or.
REQ-024 V = 1 when operands (b inverted for sub) share sign and sum sign differs; V = 0 for and/or.
REQ-025 A requester dropping reqN_valid before grant SHALL cause no side effect; operands SHALL be sampled only on grant.
REQ-026 Requests arriving in EXEC/RESP SHALL wait; rsp_ready asserted outside RESP SHALL be ignored.

Reset
REQ-027 reset SHALL force state IDLE, priority pointer to 0, rsp_valid 0, rsp_result 0, rsp_flags 0, rsp_id 0, both reqN_ready 0, immediately, independent of clk.
REQ-028 reset asserted in EXEC or RESP SHALL discard the in-flight operation; no response is produced for it after release.
REQ-029 First grant after reset release SHALL occur no earlier than the first rising edge with reset low.

Structure
REQ-030 ALUControl encodings, flag bit positions and FSM state encoding SHALL live in shared package alu_pkg.
REQ-031 Arithmetic/flag logic SHALL be a combinational sub-module alu_core (WIDTH-parameterized, a, b, ALUControl -> Result, ALUFlags) instantiated once.
REQ-032 Arbiter/FSM and output registers SHALL reside in alu_arbiter; no combinational path from reqN_* inputs to rsp_* outputs.

Verification
REQ-033 req0 add a=5 b=3, rsp_ready=1 -> rsp_valid at T+2, result=8, flags=0000, id=0.
REQ-034 req1 add a=7 b=9 -> result=16 (10000), flags N=1 Z=0 C=0 V=1, id=1; req1 sub a=3 b=3 -> result=0, flags 0110.
REQ-035 req0 sub a=2 b=5 -> result=29 (11101), flags N=1 Z=0 C=0 V=0; req0 and a=12 b=10 -> result=8, C=V=0.
REQ-036 Both valid continuously from reset, rsp_ready=1 -> grants alternate 0,1,0,1; rsp_id sequence matches; each ready pulse exactly one cycle.
REQ-037 rsp_ready held 0 for 4 cycles in RESP -> outputs stable, no reqN_ready, accept on 5th cycle then grant resumes.
REQ-038 reset pulsed during EXEC -> all outputs 0 asynchronously, no response for aborted op, next request after release served by requester 0 priority.
